// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
//   state_t : controller FSM states
//   op_t    : which algorithm drives the shared add/sub datapath
//   cnt_w() : counter width able to hold 0..width
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  typedef enum logic {OP_MULT, OP_DIV} op_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/multdiv_if.sv
// Execute-stage bus between the pipeline and the multiply/divide sequencer.
//   master : pipeline side (drives operands and start pulses)
//   slave  : sequencer side (drives result, exception, ready strobe, busy)
interface multdiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, data_busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, data_busy
  );
endinterface

// File: rtl/multdiv_addsub.sv
// (WIDTH+1)-bit combinational adder/subtracter shared by the shift-add
// multiplier and the restoring divider.
//   a_i, b_i : operands
//   sub_i    : 1 = a_i - b_i (two's complement), 0 = a_i + b_i
//   sum_o    : result
//   cout_o   : carry out; when subtracting, 1 means a_i >= b_i (no borrow)
module multdiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);

  logic [WIDTH:0] b_x;

  assign b_x = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_x} + {{(WIDTH + 1){1'b0}}, sub_i};

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the ALU's iterative signed multiply/divide unit.
// A start pulse latches operand magnitudes and the result sign; the shared
// add/sub datapath is then stepped WIDTH times (shift-add for MULT, restoring
// shift-subtract for DIV), the sign is applied and data_resultRDY pulses once.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : data_operandA/B, ctrl_MULT/ctrl_DIV in;
//                  data_result, data_exception, data_resultRDY, data_busy out
//
// Build option: MULTDIV_EARLY_EXIT_EN -- when defined, MULT with a zero
// operand or DIV with a zero dividend (nonzero divisor) finishes one edge
// after start with result 0; otherwise those run the full WIDTH steps.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  multdiv_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;     // MULT: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0] opnd_q;    // multiplicand or divisor magnitude
  logic             neg_q;     // result sign
  logic             dz_q;      // divide by zero seen at start
  logic             ez_q;      // trivially-zero result seen at start
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  // ---------------- start decode ----------------
  logic             start;
  logic             is_mult;
  logic             ez_start;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mult = bus.ctrl_MULT;              // MULT wins when both are high
  assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
  assign a_mag   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_EARLY_EXIT_EN
  assign ez_start = is_mult ? (bus.data_operandA == '0 || bus.data_operandB == '0)
                            : (bus.data_operandA == '0 && bus.data_operandB != '0);
`else
  assign ez_start = 1'b0;
`endif

  // ---------------- shared datapath ----------------
  op_t            op;
  logic [WIDTH:0] as_a, as_b, as_sum;
  logic           as_sub, as_cout;
  logic [W2-1:0]  acc_step;

  assign op = (state_q == DIV) ? OP_DIV : OP_MULT;

  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    if (op == OP_DIV) begin
      // trial subtract of divisor from remainder with next dividend bit shifted in
      as_a   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      as_b   = {1'b0, opnd_q};
      as_sub = 1'b1;
    end else begin
      as_a   = {1'b0, acc_q[W2-1:WIDTH]};
      as_b   = acc_q[0] ? {1'b0, opnd_q} : '0;
    end
  end

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (as_a),
    .b_i    (as_b),
    .sub_i  (as_sub),
    .sum_o  (as_sum),
    .cout_o (as_cout)
  );

  always_comb begin
    acc_step = acc_q;
    if (op == OP_DIV) begin
      if (as_cout) acc_step = {as_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else         acc_step = {as_a[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
    end else begin
      // carry of the add becomes the top bit after the right shift
      acc_step = {as_sum, acc_q[WIDTH-1:1]};
    end
  end

  // ---------------- sign fix-up on the final step ----------------
  logic [W2-1:0]    prod_s;
  logic [WIDTH:0]   prod_top;
  logic             mul_ovf;
  logic [WIDTH-1:0] quo_s;
  logic             div_ovf;

  assign prod_s   = neg_q ? -acc_step : acc_step;
  assign prod_top = prod_s[W2-1:WIDTH-1];
  assign mul_ovf  = ~((&prod_top) | ~(|prod_top));
  assign quo_s    = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  // only -2^(W-1) / -1 yields a positive quotient with the top bit set
  assign div_ovf  = ~neg_q & acc_step[WIDTH-1];

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ez_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // a start in any state drops whatever was in flight
        state_q <= is_mult ? MULT : DIV;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        neg_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        dz_q    <= ~is_mult & (bus.data_operandB == '0);
        ez_q    <= ez_start;
        if (is_mult) begin
          acc_q  <= {{WIDTH{1'b0}}, b_mag};
          opnd_q <= a_mag;
        end else begin
          acc_q  <= {{WIDTH{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end
      end else begin
        case (state_q)
          MULT, DIV: begin
            if (dz_q) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              rdy_q    <= 1'b1;
              result_q <= '0;
              exc_q    <= 1'b1;
            end else if (ez_q) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              rdy_q    <= 1'b1;
              result_q <= '0;
              exc_q    <= 1'b0;
            end else begin
              acc_q <= acc_step;
              cnt_q <= cnt_q + CW'(1);
              if (cnt_q == CW'(WIDTH - 1)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                rdy_q   <= 1'b1;
                if (state_q == MULT) begin
                  result_q <= prod_s[WIDTH-1:0];
                  exc_q    <= mul_ovf;
                end else begin
                  result_q <= quo_s;
                  exc_q    <= div_ovf;
                end
              end
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_busy      = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  multdiv_if #(.WIDTH(W)) bus ();

  multdiv_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- reference model: plain signed arithmetic ----------------
  function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint p;
    int     sa, sb;
    logic [31:0] lo;
    lat = 32;
    if (is_mult) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      r  = lo;
      e  = (p != longint'($signed(lo)));
`ifdef MULTDIV_EARLY_EXIT_EN
      if (a == 0 || b == 0) lat = 1;
`endif
    end else if (b == 0) begin
      r = 32'd0; e = 1'b1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      sa = a; sb = b;
      r  = sa / sb;       // SV integer division truncates toward zero
      e  = 1'b0;
`ifdef MULTDIV_EARLY_EXIT_EN
      if (a == 0) lat = 1;
`endif
    end
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);   // t0
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // returns edges after t0 until resultRDY is seen, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.data_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", bus.data_resultRDY); end
    checks++; if (bus.data_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.data_busy); end
  endtask

  task automatic run_one(input string nm, input bit m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er; logic ee; int el, lat;
    model(m, a, b, er, ee, el);
    start_op(m, ~m, a, b);
    if (el > 1) begin
      checks++; if (bus.data_busy !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", nm, bus.data_busy); end
    end
    wait_done(lat);
    checks++; if (lat != el) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, el); end
    checks++; if (bus.data_result !== er) begin failures++; $display("FAIL %s result got=%h exp=%h (a=%h b=%h)", nm, bus.data_result, er, a, b); end
    checks++; if (bus.data_exception !== ee) begin failures++; $display("FAIL %s exc got=%b exp=%b", nm, bus.data_exception, ee); end
    checks++; if (bus.data_busy !== 1'b0) begin failures++; $display("FAIL %s busy_done got=%b exp=0", nm, bus.data_busy); end
    @(posedge clock); @(negedge clock);
    checks++; if (bus.data_resultRDY !== 1'b0) begin failures++; $display("FAIL %s rdy_width got=%b exp=0", nm, bus.data_resultRDY); end
  endtask

  task automatic test_directed();
    run_one("mul_6x7",     1'b1, 32'd6,          32'd7);
    run_one("mul_m3x5",    1'b1, -32'sd3,        32'd5);
    run_one("mul_ovf",     1'b1, 32'h0001_0000,  32'h0001_0000);
    run_one("mul_minx1",   1'b1, 32'h8000_0000,  32'd1);
    run_one("mul_zero",    1'b1, 32'd0,          -32'sd9);
    run_one("div_100_7",   1'b0, 32'd100,        32'd7);
    run_one("div_m100_7",  1'b0, -32'sd100,      32'd7);
    run_one("div_7_0",     1'b0, 32'd7,          32'd0);
    run_one("div_min_m1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF);
    run_one("div_zero",    1'b0, 32'd0,          32'd5);
    run_one("div_min_1",   1'b0, 32'h8000_0000,  32'd1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit m;
    for (int i = 0; i < 30; i++) begin
      m = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 2000)) - 32'd1000; b = 32'($urandom_range(0, 60)) - 32'd30; end
        2: begin a = $urandom; b = 32'($urandom_range(0, 8)) - 32'd4; end
        default: begin a = 32'($urandom_range(0, 70000)); b = 32'($urandom_range(0, 70000)); end
      endcase
      run_one("random", m, a, b);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    start_op(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (9) begin @(posedge clock); @(negedge clock); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.data_result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus.data_result); end
    checks++; if (bus.data_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.data_busy); end
    checks++; if (bus.data_exception !== 1'b0) begin failures++; $display("FAIL rstmid_exc got=%b exp=0", bus.data_exception); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); @(negedge clock);
      if (bus.data_resultRDY === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_rdy got=%0d pulses exp=0", seen); end
  endtask

  task automatic test_restart();
    int lat, extra = 0;
    start_op(1'b1, 1'b0, 32'd2, 32'd2);
    repeat (4) begin @(posedge clock); @(negedge clock); end
    start_op(1'b0, 1'b1, 32'd9, 32'd3);
    wait_done(lat);
    checks++; if (lat != 32) begin failures++; $display("FAIL restart_latency got=%0d exp=32", lat); end
    checks++; if (bus.data_result !== 32'd3) begin failures++; $display("FAIL restart_result got=%h exp=3", bus.data_result); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); @(negedge clock);
      if (bus.data_resultRDY === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL restart_extra_rdy got=%0d exp=0", extra); end
  endtask

  task automatic test_both();
    int lat;
    start_op(1'b1, 1'b1, 32'd8, 32'd2);
    wait_done(lat);
    checks++; if (lat != 32) begin failures++; $display("FAIL both_latency got=%0d exp=32", lat); end
    checks++; if (bus.data_result !== 32'd16) begin failures++; $display("FAIL both_result got=%h exp=10", bus.data_result); end
  endtask

  task automatic test_hold();
    logic [31:0] er; logic ee; int el, lat;
    model(1'b1, 32'hFFFF_0000, 32'h0003_0000, er, ee, el);
    start_op(1'b1, 1'b0, 32'hFFFF_0000, 32'h0003_0000);
    wait_done(lat);
    for (int n = 0; n < 6; n++) begin
      bus.data_operandA = $urandom; bus.data_operandB = $urandom;
      @(posedge clock); @(negedge clock);
    end
    checks++; if (bus.data_result !== er) begin failures++; $display("FAIL hold_result got=%h exp=%h", bus.data_result, er); end
    checks++; if (bus.data_exception !== ee) begin failures++; $display("FAIL hold_exc got=%b exp=%b", bus.data_exception, ee); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er; logic ee; int el, lat;
    start_op(1'b0, 1'b1, 32'd1000, 32'd10);
    wait_done(lat);
    // new start issued in the DONE cycle
    model(1'b1, -32'sd12, -32'sd11, er, ee, el);
    start_op(1'b1, 1'b0, -32'sd12, -32'sd11);
    checks++; if (bus.data_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.data_busy); end
    wait_done(lat);
    checks++; if (lat != el) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, el); end
    checks++; if (bus.data_result !== er) begin failures++; $display("FAIL b2b_result got=%h exp=%h", bus.data_result, er); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_restart();
    test_both();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
